// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO.
// Provides clog2, read-mode constants and a parameter-check macro.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Fails elaboration with a named generate block when cond is false.
`define FIFO_CHECK(lbl, cond) \
  if (!(cond)) begin : lbl \
    $error("sync_fifo: bad parameters"); \
  end

package fifo_pkg;

  localparam bit MODE_STD  = 1'b0;
  localparam bit MODE_FWFT = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

`endif

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Ports: clk, we/wr_addr/wr_data write side, rd_addr/rd_data read side.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO, standard or first-word-fall-through read.
// Ports: clk, rst (async, active-low), clr (sync flush),
//   wr_en/wr_data, rd_en/rd_data/rd_valid,
//   full/empty/almost_full/almost_empty/count,
//   overflow/underflow (sticky until rst or clr).
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter bit FWFT       = MODE_STD,
  parameter int AF_LEVEL   = DEPTH - 8,
  parameter int AE_LEVEL   = 8,
  localparam int CW        = clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = clog2(DEPTH);

  `FIFO_CHECK(g_chk_width, DATA_WIDTH >= 1)
  `FIFO_CHECK(g_chk_pow2,
    DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0)
  `FIFO_CHECK(g_chk_af,
    AF_LEVEL >= 0 && AF_LEVEL <= DEPTH)
  `FIFO_CHECK(g_chk_ae,
    AE_LEVEL >= 0 && AE_LEVEL < DEPTH)

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full         = count == CW'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= CW'(AF_LEVEL);
  assign almost_empty = count <= CW'(AE_LEVEL);

  assign wr_acc = wr_en & ~full & ~clr;
  assign rd_acc = rd_en & ~empty & ~clr;

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en & full)  overflow  <= 1'b1;
      if (rd_en & empty) underflow <= 1'b1;
    end
  end

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head word is presented directly; pop just advances rd_ptr.
    assign rd_data  = ram_q;
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= ram_q;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (standard and FWFT builds).
// Directed table plus hand-written multi-cycle sequences.
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [6:0] count;
  logic       overflow;
  logic       underflow;

  logic       f_clr;
  logic       f_wr;
  logic [7:0] f_d;
  logic       f_rd;
  logic [7:0] f_rd_data;
  logic       f_rv;
  logic       f_full;
  logic       f_empty;
  logic       f_af;
  logic       f_ae;
  logic [6:0] f_count;
  logic       f_ovf;
  logic       f_udf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (64),
    .FWFT       (1'b0)
  ) u_std (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (64),
    .FWFT       (1'b1)
  ) u_fwft (
    .clk          (clk),
    .rst          (rst),
    .clr          (f_clr),
    .wr_en        (f_wr),
    .wr_data      (f_d),
    .rd_en        (f_rd),
    .rd_data      (f_rd_data),
    .rd_valid     (f_rv),
    .full         (f_full),
    .empty        (f_empty),
    .almost_full  (f_af),
    .almost_empty (f_ae),
    .count        (f_count),
    .overflow     (f_ovf),
    .underflow    (f_udf)
  );

  typedef struct {
    logic       clr;
    logic       wr;
    logic [7:0] d;
    logic       rd;
    int         cnt;
    logic       rv;
    logic [7:0] rdd;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  logic [7:0] q [$];
  logic [7:0] e;

  initial begin
    tbl[0]  = '{0, 1, 8'hA1, 0, 1, 0, 8'h00, 0, 0};
    tbl[1]  = '{0, 1, 8'hA2, 0, 2, 0, 8'h00, 0, 0};
    tbl[2]  = '{0, 0, 8'h00, 1, 1, 1, 8'hA1, 0, 0};
    tbl[3]  = '{0, 0, 8'h00, 0, 1, 0, 8'hA1, 0, 0};
    tbl[4]  = '{0, 1, 8'hA3, 1, 1, 1, 8'hA2, 0, 0};
    tbl[5]  = '{0, 0, 8'h00, 1, 0, 1, 8'hA3, 0, 0};
    tbl[6]  = '{0, 0, 8'h00, 1, 0, 0, 8'hA3, 0, 1};
    tbl[7]  = '{0, 1, 8'hA4, 0, 1, 0, 8'hA3, 0, 1};
    tbl[8]  = '{1, 1, 8'hA5, 0, 0, 0, 8'hA3, 0, 0};
    tbl[9]  = '{0, 0, 8'h00, 1, 0, 0, 8'hA3, 0, 1};
    tbl[10] = '{1, 0, 8'h00, 0, 0, 0, 8'hA3, 0, 0};

    rst = 1'b0;
    idle();
    wr_data = 8'h00;
    f_clr = 1'b0;
    f_wr  = 1'b0;
    f_d   = 8'h00;
    f_rd  = 1'b0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    rst = 1'b1;

    // FWFT: word falls through without rd_en
    f_wr = 1'b1;
    f_d  = 8'h5A;
    step();
    f_wr = 1'b0;
    chk("fwft_data", 32'(f_rd_data), 32'h5A);
    chk("fwft_valid", 32'(f_rv), 1);
    chk("fwft_nempty", 32'(f_empty), 0);
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    chk("fwft_pop_empty", 32'(f_empty), 1);
    chk("fwft_pop_valid", 32'(f_rv), 0);
    f_wr = 1'b1;
    f_rd = 1'b1;
    f_d  = 8'h6B;
    step();
    f_wr = 1'b0;
    f_rd = 1'b0;
    chk("fwft_ewr_count", 32'(f_count), 1);
    chk("fwft_ewr_udf", 32'(f_udf), 1);
    chk("fwft_ewr_data", 32'(f_rd_data), 32'h6B);
    chk("fwft_ewr_valid", 32'(f_rv), 1);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      clr     = tbl[i].clr;
      wr_en   = tbl[i].wr;
      wr_data = tbl[i].d;
      rd_en   = tbl[i].rd;
      step();
      chk($sformatf("tbl%0d_count", i), 32'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d_rv", i), 32'(rd_valid), 32'(tbl[i].rv));
      chk($sformatf("tbl%0d_rd", i), 32'(rd_data), 32'(tbl[i].rdd));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_udf", i), 32'(underflow), 32'(tbl[i].udf));
      chk($sformatf("tbl%0d_empty", i), 32'(empty),
          32'(tbl[i].cnt == 0));
    end
    idle();

    // Fill to full
    for (int i = 0; i < 64; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      step();
      chk("fill_count", 32'(count), i + 1);
      chk("fill_afull", 32'(almost_full), 32'(i + 1 >= 56));
      chk("fill_full", 32'(full), 32'(i == 63));
    end
    wr_data = 8'hAA;
    step();
    idle();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 64);

    // Drain in order
    for (int i = 0; i < 64; i++) begin
      rd_en = 1'b1;
      step();
      chk("drain_data", 32'(rd_data), i);
      chk("drain_rv", 32'(rd_valid), 1);
      chk("drain_count", 32'(count), 63 - i);
    end
    rd_en = 1'b0;
    step();
    chk("drain_empty", 32'(empty), 1);
    chk("drain_rv_low", 32'(rd_valid), 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("udf_set", 32'(underflow), 1);
    chk("udf_hold", 32'(rd_data), 32'h3F);
    chk("udf_rv", 32'(rd_valid), 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_udf", 32'(underflow), 0);

    // Wrap-around
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 40; i++) begin
        wr_en   = 1'b1;
        wr_data = 8'((p == 0 ? 8'h10 : 8'h80) + i);
        step();
      end
      wr_en = 1'b0;
      for (int i = 0; i < 40; i++) begin
        rd_en = 1'b1;
        step();
        chk("wrap_data", 32'(rd_data),
            32'((p == 0 ? 8'h10 : 8'h80) + i));
      end
      rd_en = 1'b0;
      chk("wrap_count", 32'(count), 0);
    end

    // Simultaneous read/write at count 10
    for (int i = 0; i < 10; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'hC0 + i);
      q.push_back(wr_data);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 8'(8'hD0 + i);
      step();
      e = q.pop_front();
      q.push_back(8'(8'hD0 + i));
      chk("sim_data", 32'(rd_data), 32'(e));
      chk("sim_count", 32'(count), 10);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1;
      step();
      e = q.pop_front();
      chk("sim_drain", 32'(rd_data), 32'(e));
    end
    rd_en = 1'b0;
    step();
    chk("sim_empty", 32'(empty), 1);

    // Full with wr+rd
    for (int i = 0; i < 64; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i + 1);
      step();
    end
    rd_en   = 1'b1;
    wr_data = 8'hBB;
    step();
    idle();
    chk("fwr_count", 32'(count), 63);
    chk("fwr_ovf", 32'(overflow), 1);
    chk("fwr_data", 32'(rd_data), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("fwr_clr_count", 32'(count), 0);

    // Empty with wr+rd
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'h77;
    step();
    idle();
    chk("ewr_count", 32'(count), 1);
    chk("ewr_udf", 32'(underflow), 1);
    chk("ewr_rv", 32'(rd_valid), 0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("ewr_data", 32'(rd_data), 32'h77);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Flush at count 20 with overflow set
    for (int i = 0; i < 65; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 44; i++) begin
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    chk("fl_pre_count", 32'(count), 20);
    chk("fl_pre_ovf", 32'(overflow), 1);
    clr     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    step();
    idle();
    chk("fl_count", 32'(count), 0);
    chk("fl_ovf", 32'(overflow), 0);
    chk("fl_rv", 32'(rd_valid), 0);
    chk("fl_hold", 32'(rd_data), 32'd43);

    // Async reset mid-burst
    wr_en   = 1'b1;
    wr_data = 8'h11;
    step();
    wr_data = 8'h22;
    step();
    wr_data = 8'h33;
    rd_en   = 1'b1;
    step();
    chk("burst_data", 32'(rd_data), 32'h11);
    chk("burst_rv", 32'(rd_valid), 1);
    chk("burst_count", 32'(count), 2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_data", 32'(rd_data), 0);
    chk("arst_rv", 32'(rd_valid), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_aempty", 32'(almost_empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_fwft_empty", 32'(f_empty), 1);
    idle();
    #10;
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
